// File: rtl/mem_stage_if.sv
// Data-memory bus used by mem_stage: a valid/ready request channel and a
// valid-only response channel (read data or write acknowledge).
interface mem_stage_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic [ADDR_WIDTH-1:0]     mem_req_addr;
   logic                      mem_req_we;
   logic [DATA_WIDTH-1:0]     mem_req_wdata;
   logic [DATA_WIDTH/8-1:0]   mem_req_wstrb;
   logic                      mem_resp_valid;
   logic [DATA_WIDTH-1:0]     mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues load/store bus requests, formats load data,
// stalls upstream while an access is outstanding. Optional macro: MISALIGN_TRAP_EN.
module mem_stage #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 64,
   parameter int REG_ID_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ex_valid,
   input  logic                    flush_in,
   input  logic [DATA_WIDTH-1:0]   alu_in,
   input  logic [DATA_WIDTH-1:0]   store_data_in,
   input  logic [REG_ID_WIDTH-1:0] dest_in,
   input  logic                    mem_read_in,
   input  logic                    mem_write_in,
   input  logic [2:0]              funct3_in,
   input  logic [1:0]              wb_control_in,
   output logic                    stall_out,
   mem_stage_if.master             bus,
   output logic                    wb_valid,
   output logic [DATA_WIDTH-1:0]   alu_out,
   output logic [DATA_WIDTH-1:0]   mem_data_out,
   output logic [REG_ID_WIDTH-1:0] dest_out,
   output logic [1:0]              wb_control_out
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                    misalign_out
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [2:0]              r_off;
   logic [2:0]              r_funct3;
   logic                    r_we;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH-1:0]   r_mem_data;
   logic                    r_misalign;

   logic                    w_mop;
   logic                    w_misalign;
   logic                    w_wb_valid;
   logic [DATA_WIDTH/8-1:0] w_size_mask;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic [DATA_WIDTH-1:0]   w_wdata;

   // Shift the captured doubleword down to the accessed byte, then size/sign-extend.
   function automatic logic [63:0] fmt_load(input logic [63:0] word,
                                            input logic [2:0]  off,
                                            input logic [2:0]  f3);
      logic [63:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  return {{56{sh[7]}}, sh[7:0]};
         3'b100:  return {56'd0, sh[7:0]};
         3'b001:  return {{48{sh[15]}}, sh[15:0]};
         3'b101:  return {48'd0, sh[15:0]};
         3'b010:  return {{32{sh[31]}}, sh[31:0]};
         3'b110:  return {32'd0, sh[31:0]};
         default: return sh;
      endcase
   endfunction

   assign w_mop   = ex_valid & (mem_read_in | mem_write_in);
   assign w_strb  = w_size_mask << alu_in[2:0];
   assign w_wdata = store_data_in << {alu_in[2:0], 3'b000};

   always_comb begin
      w_size_mask = 8'hFF;
      case (funct3_in[1:0])
         2'b00:   w_size_mask = 8'h01;
         2'b01:   w_size_mask = 8'h03;
         2'b10:   w_size_mask = 8'h0F;
         default: w_size_mask = 8'hFF;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      w_misalign = 1'b0;
      case (funct3_in[1:0])
         2'b01:   w_misalign = alu_in[0];
         2'b10:   w_misalign = |alu_in[1:0];
         2'b11:   w_misalign = |alu_in[2:0];
         default: w_misalign = 1'b0;
      endcase
   end
   assign misalign_out = r_misalign;
`else
   assign w_misalign = 1'b0;
`endif

   // Non-mops also pass through while draining, since stall_out does not hold them.
   always_comb begin
      w_wb_valid = 1'b0;
      case (r_state)
         S_IDLE, S_DRAIN: w_wb_valid = ex_valid & ~w_mop & ~flush_in;
         S_DONE:          w_wb_valid = r_misalign | ~flush_in;
         default:         w_wb_valid = 1'b0;
      endcase
   end

   assign wb_valid       = w_wb_valid;
   assign stall_out      = w_mop & (r_state != S_DONE);
   assign alu_out        = alu_in;
   assign dest_out       = dest_in;
   assign wb_control_out = {wb_control_in[1] & w_wb_valid & ~r_misalign, wb_control_in[0]};
   assign mem_data_out   = r_mem_data;

   assign bus.mem_req_valid = (r_state == S_REQ);
   assign bus.mem_req_addr  = r_addr;
   assign bus.mem_req_we    = r_we;
   assign bus.mem_req_wdata = r_wdata;
   assign bus.mem_req_wstrb = r_wstrb;

   // Access sequencer; request fields are captured once in IDLE and held until accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_addr     <= {ADDR_WIDTH{1'b0}};
         r_off      <= 3'd0;
         r_funct3   <= 3'd0;
         r_we       <= 1'b0;
         r_wstrb    <= {(DATA_WIDTH/8){1'b0}};
         r_wdata    <= {DATA_WIDTH{1'b0}};
         r_mem_data <= {DATA_WIDTH{1'b0}};
         r_misalign <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mop && !flush_in) begin
                  if (w_misalign) begin
                     r_misalign <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_addr   <= {alu_in[ADDR_WIDTH-1:3], 3'b000};
                     r_off    <= alu_in[2:0];
                     r_funct3 <= funct3_in;
                     r_we     <= mem_write_in;
                     r_wstrb  <= mem_write_in ? w_strb : {(DATA_WIDTH/8){1'b0}};
                     r_wdata  <= mem_write_in ? w_wdata : {DATA_WIDTH{1'b0}};
                     r_state  <= S_REQ;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_REQ: begin
               // An accepted request owes a response even if flushed in the same cycle.
               if (bus.mem_req_ready) begin
                  r_state <= flush_in ? S_DRAIN : S_WAIT;
               end else if (flush_in) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_REQ;
               end
            end
            S_WAIT: begin
               if (flush_in) begin
                  r_state <= bus.mem_resp_valid ? S_IDLE : S_DRAIN;
               end else if (bus.mem_resp_valid) begin
                  r_mem_data <= r_we ? 64'd0 : fmt_load(bus.mem_resp_data, r_off, r_funct3);
                  r_state    <= S_DONE;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_DONE: begin
               r_mem_data <= {DATA_WIDTH{1'b0}};
               r_misalign <= 1'b0;
               r_state    <= S_IDLE;
            end
            S_DRAIN: begin
               r_state <= bus.mem_resp_valid ? S_IDLE : S_DRAIN;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
